dmem_responder: RTL

Data-memory responder for the MIPS processor: the memory end of the load/store interface that the datapath drives through its ALU address and write-data outputs. It accepts one request at a time over a valid/ready handshake, waits a fixed, programmable access latency, then returns one response pulse. Each request is a byte, halfword, or word access with sign or zero extension on loads. The block replaces the zero-latency data memory so the processor and its stall logic can be exercised against realistic memory timing.

---
 rtl/dmem_responder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready, fixed access
// latency, single-cycle response pulse with byte/halfword/word lane handling.
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        accept, commit;

    logic          we_p0;
    logic [1:0]    size_p0;
    logic          signed_p0;
    logic [AW+1:0] addr_p0;
    logic [31:0]   wdata_p0;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [31:0]   rd_word;
    logic          err;

    // Address bits above the array size alias onto the same words.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:AW+2];

    function automatic logic access_err(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return a[0];
            2'b10:   return a != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [1:0] size, input logic [1:0] a);
        logic [31:0] w;
        w = old;
        case (size)
            2'b00:   w[{a, 3'b000} +: 8]     = wd[7:0];
            2'b01:   w[{a[1], 4'b0000} +: 16] = wd[15:0];
            2'b10:   w = wd;
            default: w = old;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic sgn, input logic [1:0] a);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] r;
        b = word[{a, 3'b000} +: 8];
        h = word[{a[1], 4'b0000} +: 16];
        case (size)
            2'b00:   r = sgn ? 32'(b) : {24'h0, b};
            2'b01:   r = sgn ? 32'(h) : {16'h0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    assign idx     = addr_p0[AW+1:2];
    assign lane    = addr_p0[1:0];
    assign rd_word = mem[idx];
    assign err     = access_err(size_p0, lane);
    assign accept  = (state == IDLE) && req_valid;
    assign commit  = (state == BUSY) && (cnt == 4'd0);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = BUSY;
                    cnt_next   = 4'(LATENCY - 1);
                end
            end
            BUSY: begin
                if (cnt == 4'd0) state_next = RESP;
                else             cnt_next   = cnt - 4'd1;
            end
            RESP: begin
                rsp_valid  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (commit) begin
                rsp_err   <= err;
                rsp_rdata <= (err || we_p0) ? 32'h0 : load_extend(rd_word, size_p0, signed_p0, lane);
            end
        end
    end

    // Request capture stage: fields frozen at acceptance.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0     <= req_we;
            size_p0   <= req_size;
            signed_p0 <= req_signed;
            addr_p0   <= req_addr[AW+1:0];
            wdata_p0  <= req_wdata;
        end
    end

    // Commit stage: reset in BUSY suppresses the write.
    always_ff @(posedge clk) begin
        if (commit && !reset && we_p0 && !err)
            mem[idx] <= store_merge(rd_word, wdata_p0, size_p0, lane);
    end

endmodule
